// File: rtl/reg_file_ctx.sv
// reg_file_ctx: windowed register file with a full shadow bank and a
// multi-cycle save/restore sequencer for context switching.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (clears regs, shadow, FSM)
//   write        write enable for the rd window
//   rd_addr      write window offset (physical index = RD_BASE + rd_addr)
//   rd_in        write data
//   rs_addr      read window A offset (physical index = RS_BASE + rs_addr)
//   rt_addr      read window B offset (physical index = RT_BASE + rt_addr)
//   rs_out       combinational read A (0 for an out-of-range index)
//   rt_out       combinational read B (0 for an out-of-range index)
//   save_req     request copy regs -> shadow
//   restore_req  request copy shadow -> regs
//   busy         save/restore in progress (writes and requests ignored)
//   done         one-cycle pulse in IDLE after the final copy
//
// Optional feature macro: REG_FILE_CTX_BYPASS_EN
//   When defined, a write that is accepted this cycle is forwarded to any
//   read port addressing the same legal physical index. When undefined, reads
//   show the stored value until after the edge and no forwarding is built.

module reg_file_ctx #(
   parameter int unsigned NUM_REG   = 12,
   parameter int unsigned REG_WIDTH = 8,
   parameter int unsigned RS_AW     = 4,
   parameter int unsigned RT_AW     = 3,
   parameter int unsigned RD_AW     = 2,
   parameter int unsigned RS_BASE   = 0,
   parameter int unsigned RT_BASE   = 4,
   parameter int unsigned RD_BASE   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic [RD_AW-1:0]     rd_addr,
   input  logic [REG_WIDTH-1:0] rd_in,
   input  logic [RS_AW-1:0]     rs_addr,
   input  logic [RT_AW-1:0]     rt_addr,
   output logic [REG_WIDTH-1:0] rs_out,
   output logic [REG_WIDTH-1:0] rt_out,
   input  logic                 save_req,
   input  logic                 restore_req,
   output logic                 busy,
   output logic                 done
);

   // Physical index width: one extra bit so BASE + offset overflow is visible.
   localparam int unsigned IW   = $clog2(NUM_REG) + 1;
   // Array select width: just enough to address NUM_REG entries.
   localparam int unsigned AW   = $clog2(NUM_REG);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REG - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2
   } state_t;

   // Storage
   logic [REG_WIDTH-1:0] regs   [NUM_REG];
   logic [REG_WIDTH-1:0] shadow [NUM_REG];

   // Sequencer state
   state_t          state_q;
   state_t          state_d;
   logic [AW-1:0]   idx_q;
   logic [AW-1:0]   idx_d;
   logic            done_q;
   logic            done_d;
   logic            busy_q;

   // Window decode
   logic [IW-1:0]   rs_idx_c;
   logic [IW-1:0]   rt_idx_c;
   logic [IW-1:0]   rd_idx_c;
   logic            rs_legal_c;
   logic            rt_legal_c;
   logic            rd_legal_c;
   logic            wr_en_c;
   logic [REG_WIDTH-1:0] rs_rd_c;
   logic [REG_WIDTH-1:0] rt_rd_c;

   // Physical index = BASE + offset at IW bits, then a range check.
   always_comb begin
      rs_idx_c   = IW'(RS_BASE) + IW'(rs_addr);
      rt_idx_c   = IW'(RT_BASE) + IW'(rt_addr);
      rd_idx_c   = IW'(RD_BASE) + IW'(rd_addr);
      rs_legal_c = (rs_idx_c < IW'(NUM_REG));
      rt_legal_c = (rt_idx_c < IW'(NUM_REG));
      rd_legal_c = (rd_idx_c < IW'(NUM_REG));
   end

   // Datapath stalls while the sequencer owns the register file.
   assign wr_en_c = write && !busy_q && rd_legal_c;

   // Raw array reads; illegal indices are forced to zero.
   always_comb begin
      rs_rd_c = '0;
      rt_rd_c = '0;
      if (rs_legal_c) rs_rd_c = regs[AW'(rs_idx_c)];
      if (rt_legal_c) rt_rd_c = regs[AW'(rt_idx_c)];
   end

`ifdef REG_FILE_CTX_BYPASS_EN
   // Forward an accepted write to a read port hitting the same index.
   always_comb begin
      rs_out = rs_rd_c;
      rt_out = rt_rd_c;
      if (wr_en_c && rs_legal_c && (rs_idx_c == rd_idx_c)) rs_out = rd_in;
      if (wr_en_c && rt_legal_c && (rt_idx_c == rd_idx_c)) rt_out = rd_in;
   end
`else
   assign rs_out = rs_rd_c;
   assign rt_out = rt_rd_c;
`endif

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Sequencer next-state: save beats restore; requests while busy are dropped.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (save_req) begin
               state_d = ST_SAVE;
               idx_d   = '0;
            end else if (restore_req) begin
               state_d = ST_RESTORE;
               idx_d   = '0;
            end
         end
         ST_SAVE, ST_RESTORE: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Register and shadow storage: reset, one copy per cycle, or a normal write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REG); i++) begin
            regs[i]   <= '0;
            shadow[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_SAVE:    shadow[idx_q] <= regs[idx_q];
            ST_RESTORE: regs[idx_q]   <= shadow[idx_q];
            default: begin
               if (wr_en_c) regs[AW'(rd_idx_c)] <= rd_in;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_reg_file_ctx.sv
// tb_reg_file_ctx: directed self-checking bench for reg_file_ctx using the
// default parameter set (12 registers, windows at 0 / 4 / 8).

module tb_reg_file_ctx;

   logic       clk;
   logic       reset;
   logic       write;
   logic [1:0] rd_addr;
   logic [7:0] rd_in;
   logic [3:0] rs_addr;
   logic [2:0] rt_addr;
   logic [7:0] rs_out;
   logic [7:0] rt_out;
   logic       save_req;
   logic       restore_req;
   logic       busy;
   logic       done;

   int pass_cnt = 0;
   int total    = 0;

   reg_file_ctx dut (
      .clk         (clk),
      .reset       (reset),
      .write       (write),
      .rd_addr     (rd_addr),
      .rd_in       (rd_in),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rs_out      (rs_out),
      .rt_out      (rt_out),
      .save_req    (save_req),
      .restore_req (restore_req),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rs(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rs_addr = a;
      #1;
      check(tag, {24'h0, rs_out}, {24'h0, exp});
   endtask

   task automatic chk_rt(input string tag, input logic [2:0] a, input logic [7:0] exp);
      rt_addr = a;
      #1;
      check(tag, {24'h0, rt_out}, {24'h0, exp});
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      write   = 1'b1;
      rd_addr = a;
      rd_in   = d;
      tick();
      write   = 1'b0;
   endtask

   // Called right after the accepting edge: busy for exactly 12 cycles, then done.
   task automatic run_busy(input string tag);
      for (int i = 0; i < 12; i++) begin
         check({tag, "_busy"}, {31'h0, busy}, 32'h1);
         check({tag, "_nodone"}, {31'h0, done}, 32'h0);
         tick();
      end
      check({tag, "_idle"}, {31'h0, busy}, 32'h0);
      check({tag, "_done"}, {31'h0, done}, 32'h1);
   endtask

   initial begin
      reset = 1'b1; write = 1'b0; rd_addr = '0; rd_in = '0;
      rs_addr = '0; rt_addr = '0; save_req = 1'b0; restore_req = 1'b0;

      // 1. Reset then read
      tick();
      reset = 1'b0;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      for (int i = 0; i < 12; i++) chk_rs("rst_rs", 4'(i), 8'h00);
      for (int i = 0; i < 8; i++)  chk_rt("rst_rt", 3'(i), 8'h00);
      chk_rs("rs_oob", 4'd15, 8'h00);

      // 2. Windowed write / read
      write = 1'b1; rd_addr = 2'd2; rd_in = 8'hA5;
      rs_addr = 4'd10; rt_addr = 3'd6;
      #1;
`ifdef REG_FILE_CTX_BYPASS_EN
      check("fwd_rs", {24'h0, rs_out}, 32'hA5);
      check("fwd_rt", {24'h0, rt_out}, 32'hA5);
`else
      check("nofwd_rs", {24'h0, rs_out}, 32'h00);
      check("nofwd_rt", {24'h0, rt_out}, 32'h00);
`endif
      tick();
      write = 1'b0;
      chk_rs("wr_rs10", 4'd10, 8'hA5);
      chk_rt("wr_rt6", 3'd6, 8'hA5);
      chk_rs("wr_rs9_untouched", 4'd9, 8'h00);

      // 3. Save / restore round trip
      wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
      chk_rs("ld_r8", 4'd8, 8'h11);
      chk_rt("ld_r11", 3'd7, 8'h44);
      save_req = 1'b1; tick(); save_req = 1'b0;
      run_busy("save1");
      tick();
      check("save1_done_clr", {31'h0, done}, 32'h0);
      wr(2'd0, 8'hFF);
      chk_rs("ovw_r8", 4'd8, 8'hFF);
      restore_req = 1'b1; tick(); restore_req = 1'b0;
      run_busy("rest1");
      chk_rs("rest1_r8", 4'd8, 8'h11);
      chk_rs("rest1_r9", 4'd9, 8'h22);
      chk_rs("rest1_r10", 4'd10, 8'h33);
      chk_rs("rest1_r11", 4'd11, 8'h44);
      tick();

      // 4. Write during busy is dropped
      save_req = 1'b1; tick(); save_req = 1'b0;
      write = 1'b1; rd_addr = 2'd1; rd_in = 8'h5A;
      run_busy("save2");
      write = 1'b0;
      chk_rs("busy_wr_r9", 4'd9, 8'h22);
      tick();

      // 5. Simultaneous requests: save wins, restore dropped
      wr(2'd0, 8'h77);
      save_req = 1'b1; restore_req = 1'b1; tick();
      save_req = 1'b0; restore_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("both_busy", {31'h0, busy}, 32'h1);
         restore_req = (i == 3);
         tick();
      end
      restore_req = 1'b0;
      check("both_done", {31'h0, done}, 32'h1);
      tick();
      check("both_one_done", {31'h0, done}, 32'h0);
      check("both_no_queue", {31'h0, busy}, 32'h0);
      chk_rs("both_regs_kept", 4'd8, 8'h77);
      wr(2'd0, 8'h99);
      restore_req = 1'b1; tick(); restore_req = 1'b0;
      run_busy("rest2");
      chk_rs("both_shadow_new", 4'd8, 8'h77);
      tick();

      // 6. Reset mid-restore
      wr(2'd0, 8'h55);
      restore_req = 1'b1; tick(); restore_req = 1'b0;
      tick(); tick(); tick(); tick();
      check("mid_busy", {31'h0, busy}, 32'h1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("mid_rst_busy", {31'h0, busy}, 32'h0);
      check("mid_rst_done", {31'h0, done}, 32'h0);
      for (int i = 0; i < 12; i++) chk_rs("mid_rst_regs", 4'(i), 8'h00);
      wr(2'd0, 8'h55);
      restore_req = 1'b1; tick(); restore_req = 1'b0;
      run_busy("rest3");
      chk_rs("mid_rst_shadow", 4'd8, 8'h00);
      chk_rs("mid_rst_shadow_r2", 4'd2, 8'h00);
      tick();
      wr(2'd0, 8'h66);
      wr(2'd3, 8'hC3);
      save_req = 1'b1; tick(); save_req = 1'b0;
      run_busy("save3");
      tick();
      wr(2'd0, 8'h00);
      wr(2'd3, 8'h00);
      restore_req = 1'b1; tick(); restore_req = 1'b0;
      run_busy("rest4");
      chk_rs("post_rst_r8", 4'd8, 8'h66);
      chk_rs("post_rst_r11", 4'd11, 8'hC3);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
